// File: rtl/uart_csr_bridge_pkg.sv
// Shared constants, state encodings and packed types for the UART-to-CSR debug bridge.
// Holds the protocol byte codes, the FSM encodings, the latched CSR request and the baud divisor helper.
package uart_csr_bridge_pkg;

   localparam int CSR_AW = 15;
   localparam int CSR_DW = 32;

   localparam logic [7:0] CMD_WRITE = 8'h01;
   localparam logic [7:0] CMD_READ  = 8'h02;
   localparam logic [7:0] REPLY_ACK = 8'hAA;
   localparam logic [7:0] REPLY_NAK = 8'hEE;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_CMD_ADDR_H,
      ST_CMD_ADDR_L,
      ST_CMD_DATA,
      ST_EXEC_WR,
      ST_EXEC_RD,
      ST_RD_SAMPLE,
      ST_RESP
   } state_e;

   typedef enum logic [2:0] {
      RX_HUNT,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_WAIT_HI
   } rx_state_e;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_e;

   typedef struct packed {
      logic [CSR_AW-1:0] addr;
      logic [CSR_DW-1:0] data;
   } csr_req_t;

   // Cycles per 16x oversampling tick; never below one so the PHY always advances.
   function automatic int unsigned calc_divisor(input int unsigned clk_freq, input int unsigned baud);
      int unsigned div;
      div = clk_freq / baud / 16;
      return (div == 0) ? 1 : div;
   endfunction

endpackage

// File: rtl/uart_csr_bridge_if.sv
// CSR bus between the bridge (master) and the peripheral fabric (slave).
// Read data is expected one cycle after the address is presented.
interface uart_csr_bridge_if;
   import uart_csr_bridge_pkg::*;

   logic [CSR_AW-1:0] csr_a;
   logic              csr_we;
   logic [CSR_DW-1:0] csr_do;
   logic [CSR_DW-1:0] csr_di;

   modport master (output csr_a, output csr_we, output csr_do, input csr_di);
   modport slave  (input csr_a, input csr_we, input csr_do, output csr_di);

endinterface

// File: rtl/uart_bridge_phy.sv
// 8N1 UART PHY: rx synchroniser, 16x tick, deserialiser (rx_done pulse) and serialiser (tx_done pulse).
// rx_done one cycle after the mid-stop sample; tx_wr accepted only while tx_idle_o, no queueing.
module uart_bridge_phy
   import uart_csr_bridge_pkg::*;
#(
   parameter int unsigned DIVISOR = 1
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       rx_i,
   output logic       tx_o,
   output logic [7:0] rx_data_o,
   output logic       rx_done_o,
   input  logic [7:0] tx_data_i,
   input  logic       tx_wr_i,
   output logic       tx_idle_o,
   output logic       tx_done_o
);

   localparam int unsigned DIV_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

   logic [DIV_W-1:0] div_q, div_d;
   logic             tick;
   logic             rx_meta_q, rx_sync_q;

   rx_state_e  rx_st_q, rx_st_d;
   logic [3:0] rx_os_q, rx_os_d;
   logic [2:0] rx_bit_q, rx_bit_d;
   logic [7:0] rx_sh_q, rx_sh_d;
   logic       rx_done_q, rx_done_d;

   tx_state_e  tx_st_q, tx_st_d;
   logic [3:0] tx_os_q, tx_os_d;
   logic [2:0] tx_bit_q, tx_bit_d;
   logic [7:0] tx_sh_q, tx_sh_d;
   logic       tx_q, tx_d;
   logic       tx_done_q, tx_done_d;

   always_comb begin
      tick  = (div_q == DIV_W'(DIVISOR - 1));
      div_d = tick ? '0 : div_q + 1'b1;
   end

   // A low stop bit leaves the line low; RX_WAIT_HI keeps that tail from looking like a new start.
   always_comb begin
      rx_st_d   = rx_st_q;
      rx_os_d   = rx_os_q;
      rx_bit_d  = rx_bit_q;
      rx_sh_d   = rx_sh_q;
      rx_done_d = 1'b0;
      case (rx_st_q)
         RX_HUNT: begin
            if (!rx_sync_q) begin
               rx_st_d = RX_START;
               rx_os_d = '0;
            end
         end
         RX_START: begin
            if (tick) begin
               if (rx_os_q == 4'd7) begin
                  rx_os_d  = '0;
                  rx_bit_d = '0;
                  rx_st_d  = rx_sync_q ? RX_HUNT : RX_DATA;
               end else begin
                  rx_os_d = rx_os_q + 4'd1;
               end
            end
         end
         RX_DATA: begin
            if (tick) begin
               if (rx_os_q == 4'd15) begin
                  rx_os_d = '0;
                  rx_sh_d = {rx_sync_q, rx_sh_q[7:1]};
                  if (rx_bit_q == 3'd7) rx_st_d = RX_STOP;
                  else                  rx_bit_d = rx_bit_q + 3'd1;
               end else begin
                  rx_os_d = rx_os_q + 4'd1;
               end
            end
         end
         RX_STOP: begin
            if (tick) begin
               if (rx_os_q == 4'd15) begin
                  rx_os_d = '0;
                  if (rx_sync_q) begin
                     rx_done_d = 1'b1;
                     rx_st_d   = RX_HUNT;
                  end else begin
                     rx_st_d = RX_WAIT_HI;
                  end
               end else begin
                  rx_os_d = rx_os_q + 4'd1;
               end
            end
         end
         RX_WAIT_HI: begin
            if (rx_sync_q) rx_st_d = RX_HUNT;
         end
         default: rx_st_d = RX_HUNT;
      endcase
   end

   always_comb begin
      tx_st_d   = tx_st_q;
      tx_os_d   = tx_os_q;
      tx_bit_d  = tx_bit_q;
      tx_sh_d   = tx_sh_q;
      tx_done_d = 1'b0;
      case (tx_st_q)
         TX_IDLE: begin
            if (tx_wr_i) begin
               tx_sh_d = tx_data_i;
               tx_os_d = '0;
               tx_st_d = TX_START;
            end
         end
         TX_START: begin
            if (tick) begin
               if (tx_os_q == 4'd15) begin
                  tx_os_d  = '0;
                  tx_bit_d = '0;
                  tx_st_d  = TX_DATA;
               end else begin
                  tx_os_d = tx_os_q + 4'd1;
               end
            end
         end
         TX_DATA: begin
            if (tick) begin
               if (tx_os_q == 4'd15) begin
                  tx_os_d = '0;
                  tx_sh_d = {1'b0, tx_sh_q[7:1]};
                  if (tx_bit_q == 3'd7) tx_st_d = TX_STOP;
                  else                  tx_bit_d = tx_bit_q + 3'd1;
               end else begin
                  tx_os_d = tx_os_q + 4'd1;
               end
            end
         end
         TX_STOP: begin
            if (tick) begin
               if (tx_os_q == 4'd15) begin
                  tx_os_d   = '0;
                  tx_st_d   = TX_IDLE;
                  tx_done_d = 1'b1;
               end else begin
                  tx_os_d = tx_os_q + 4'd1;
               end
            end
         end
         default: tx_st_d = TX_IDLE;
      endcase
      tx_d = (tx_st_d == TX_START) ? 1'b0 :
             (tx_st_d == TX_DATA)  ? tx_sh_d[0] : 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         div_q     <= '0;
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         rx_st_q   <= RX_HUNT;
         rx_os_q   <= '0;
         rx_bit_q  <= '0;
         rx_sh_q   <= '0;
         rx_done_q <= 1'b0;
         tx_st_q   <= TX_IDLE;
         tx_os_q   <= '0;
         tx_bit_q  <= '0;
         tx_sh_q   <= '0;
         tx_q      <= 1'b1;
         tx_done_q <= 1'b0;
      end else begin
         div_q     <= div_d;
         rx_meta_q <= rx_i;
         rx_sync_q <= rx_meta_q;
         rx_st_q   <= rx_st_d;
         rx_os_q   <= rx_os_d;
         rx_bit_q  <= rx_bit_d;
         rx_sh_q   <= rx_sh_d;
         rx_done_q <= rx_done_d;
         tx_st_q   <= tx_st_d;
         tx_os_q   <= tx_os_d;
         tx_bit_q  <= tx_bit_d;
         tx_sh_q   <= tx_sh_d;
         tx_q      <= tx_d;
         tx_done_q <= tx_done_d;
      end
   end

   assign rx_data_o = rx_sh_q;
   assign rx_done_o = rx_done_q;
   assign tx_o      = tx_q;
   assign tx_idle_o = (tx_st_q == TX_IDLE);
   assign tx_done_o = tx_done_q;

endmodule

// File: rtl/uart_csr_bridge.sv
// UART-controlled CSR initiator: 01 AH AL D3..D0 writes (reply AA), 02 AH AL reads (reply 4 bytes), else reply EE.
// Bytes arriving while executing or replying are dropped; UART_CSR_BRIDGE_TIMEOUT_EN adds an inter-byte abort.
module uart_csr_bridge
   import uart_csr_bridge_pkg::*;
#(
   parameter int unsigned clk_freq = 100000000,
   parameter int unsigned baud     = 115200,
   parameter int unsigned timeout  = 1000000
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic              uart_rx,
   output logic              uart_tx,
   output logic              busy,
   uart_csr_bridge_if.master csr
);

   localparam int unsigned DIVISOR = calc_divisor(clk_freq, baud);

   logic [7:0] rx_data;
   logic       rx_done;
   logic       tx_wr;
   logic [7:0] tx_data;
   logic       tx_idle;
   logic       tx_done;
   logic       timeout_hit;

   state_e      state_q, state_d;
   logic        is_wr_q, is_wr_d;
   logic [14:0] addr_q, addr_d;
   logic [31:0] data_q, data_d;
   logic [1:0]  byte_cnt_q, byte_cnt_d;
   logic [2:0]  resp_cnt_q, resp_cnt_d;
   logic        tx_sent_q, tx_sent_d;
   csr_req_t    req_q, req_d;

   uart_bridge_phy #(
      .DIVISOR (DIVISOR)
   ) u_phy (
      .clk_i     (sys_clk),
      .rst_ni    (sys_rst_n),
      .rx_i      (uart_rx),
      .tx_o      (uart_tx),
      .rx_data_o (rx_data),
      .rx_done_o (rx_done),
      .tx_data_i (tx_data),
      .tx_wr_i   (tx_wr),
      .tx_idle_o (tx_idle),
      .tx_done_o (tx_done)
   );

   // data_q doubles as the reply buffer: the top byte is always the next one to send.
   always_comb begin
      state_d    = state_q;
      is_wr_d    = is_wr_q;
      addr_d     = addr_q;
      data_d     = data_q;
      byte_cnt_d = byte_cnt_q;
      resp_cnt_d = resp_cnt_q;
      tx_sent_d  = tx_sent_q;
      req_d      = req_q;
      tx_wr      = 1'b0;
      tx_data    = data_q[31:24];
      case (state_q)
         ST_IDLE: begin
            if (rx_done) begin
               if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
                  is_wr_d = (rx_data == CMD_WRITE);
                  state_d = ST_CMD_ADDR_H;
               end else begin
                  data_d     = {REPLY_NAK, 24'h0};
                  resp_cnt_d = 3'd1;
                  tx_sent_d  = 1'b0;
                  state_d    = ST_RESP;
               end
            end
         end
         ST_CMD_ADDR_H: begin
            if (rx_done) begin
               addr_d[14:8] = rx_data[6:0];
               state_d      = ST_CMD_ADDR_L;
            end
         end
         ST_CMD_ADDR_L: begin
            if (rx_done) begin
               addr_d[7:0] = rx_data;
               if (is_wr_q) begin
                  byte_cnt_d = '0;
                  state_d    = ST_CMD_DATA;
               end else begin
                  req_d.addr = {addr_q[14:8], rx_data};
                  state_d    = ST_EXEC_RD;
               end
            end
         end
         ST_CMD_DATA: begin
            if (rx_done) begin
               data_d = {data_q[23:0], rx_data};
               if (byte_cnt_q == 2'd3) begin
                  req_d.addr = addr_q;
                  req_d.data = {data_q[23:0], rx_data};
                  state_d    = ST_EXEC_WR;
               end else begin
                  byte_cnt_d = byte_cnt_q + 2'd1;
               end
            end
         end
         ST_EXEC_WR: begin
            data_d     = {REPLY_ACK, 24'h0};
            resp_cnt_d = 3'd1;
            tx_sent_d  = 1'b0;
            state_d    = ST_RESP;
         end
         ST_EXEC_RD: begin
            state_d = ST_RD_SAMPLE;
         end
         ST_RD_SAMPLE: begin
            data_d     = csr.csr_di;
            resp_cnt_d = 3'd4;
            tx_sent_d  = 1'b0;
            state_d    = ST_RESP;
         end
         ST_RESP: begin
            if (!tx_sent_q && tx_idle) begin
               tx_wr     = 1'b1;
               tx_sent_d = 1'b1;
            end
            if (tx_done) begin
               data_d    = {data_q[23:0], 8'h00};
               tx_sent_d = 1'b0;
               if (resp_cnt_q == 3'd1) state_d = ST_IDLE;
               else                    resp_cnt_d = resp_cnt_q - 3'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (timeout_hit) state_d = ST_IDLE;
   end

`ifdef UART_CSR_BRIDGE_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(timeout + 1);

   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic            in_cmd;

   always_comb begin
      in_cmd      = (state_q == ST_CMD_ADDR_H) || (state_q == ST_CMD_ADDR_L) ||
                    (state_q == ST_CMD_DATA);
      to_cnt_d    = '0;
      timeout_hit = 1'b0;
      if (in_cmd && !rx_done) begin
         if (to_cnt_q == TO_W'(timeout - 1)) timeout_hit = 1'b1;
         else                                to_cnt_d    = to_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) to_cnt_q <= '0;
      else            to_cnt_q <= to_cnt_d;
   end
`else
   logic timeout_unused;
   assign timeout_unused = (timeout != 0);
   assign timeout_hit    = 1'b0;
`endif

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state_q    <= ST_IDLE;
         is_wr_q    <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         byte_cnt_q <= '0;
         resp_cnt_q <= '0;
         tx_sent_q  <= 1'b0;
         req_q      <= '0;
      end else begin
         state_q    <= state_d;
         is_wr_q    <= is_wr_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         byte_cnt_q <= byte_cnt_d;
         resp_cnt_q <= resp_cnt_d;
         tx_sent_q  <= tx_sent_d;
         req_q      <= req_d;
      end
   end

   assign csr.csr_a  = req_q.addr;
   assign csr.csr_do = req_q.data;
   assign csr.csr_we = (state_q == ST_EXEC_WR);
   assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_csr_bridge.sv
// Bench for uart_csr_bridge: protocol-level byte model plus CSR slave, UART line driver and decoder.
// Bit period is 16 clocks (16 MHz clock, 1 Mbaud); inter-byte timeout parameter 2000 cycles.
module tb_uart_csr_bridge;

   logic clk = 1'b0;
   logic sys_rst_n = 1'b0;
   logic uart_rx = 1'b1;
   logic uart_tx;
   logic busy;
   logic rst_at_edge = 1'b1;

   int n_pass = 0;
   int n_chk  = 0;

   uart_csr_bridge_if bus ();

   uart_csr_bridge #(
      .clk_freq (16000000),
      .baud     (1000000),
      .timeout  (2000)
   ) dut (
      .sys_clk   (clk),
      .sys_rst_n (sys_rst_n),
      .uart_rx   (uart_rx),
      .uart_tx   (uart_tx),
      .busy      (busy),
      .csr       (bus)
   );

   always #5 clk = ~clk;

   logic [7:0]  cmd_buf[$];
   logic [46:0] exp_wr[$];
   logic [7:0]  exp_tx[$];
   logic [46:0] wr_log[$];
   logic [7:0]  tx_log[$];

   function automatic logic [31:0] csr_rd_fn(input logic [14:0] a);
      if (a == 15'h0001) return 32'h1234_5678;
      return {a, 2'b01, a};
   endfunction

   always @(posedge clk) bus.csr_di <= csr_rd_fn(bus.csr_a);
   always @(posedge clk) rst_at_edge = sys_rst_n;

   task automatic check(input string name, input logic [46:0] act, input logic [46:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
   endtask

   // Command-level model: whole frames in, expected CSR writes and reply bytes out.
   task automatic model_byte(input logic [7:0] b);
      logic [7:0]  ah, al;
      logic [14:0] a;
      logic [31:0] d;
      cmd_buf.push_back(b);
      if (cmd_buf[0] == 8'h01) begin
         if (cmd_buf.size() == 7) begin
            ah = cmd_buf[1];
            al = cmd_buf[2];
            a  = {ah[6:0], al};
            d  = {cmd_buf[3], cmd_buf[4], cmd_buf[5], cmd_buf[6]};
            exp_wr.push_back({a, d});
            exp_tx.push_back(8'hAA);
            cmd_buf.delete();
         end
      end else if (cmd_buf[0] == 8'h02) begin
         if (cmd_buf.size() == 3) begin
            ah = cmd_buf[1];
            al = cmd_buf[2];
            d  = csr_rd_fn({ah[6:0], al});
            exp_tx.push_back(d[31:24]);
            exp_tx.push_back(d[23:16]);
            exp_tx.push_back(d[15:8]);
            exp_tx.push_back(d[7:0]);
            cmd_buf.delete();
         end
      end else begin
         exp_tx.push_back(8'hEE);
         cmd_buf.delete();
      end
   endtask

   task automatic drive_bit(input logic v);
      @(negedge clk);
      uart_rx = v;
      repeat (15) @(negedge clk);
   endtask

   // The model is fed before the stop bit so expectations exist before the DUT can act.
   task automatic uart_send(input logic [7:0] b, input logic stop_bit, input bit feed);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
      if (feed) model_byte(b);
      drive_bit(stop_bit);
      if (!stop_bit) drive_bit(1'b1);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while ((busy !== 1'b0 || exp_tx.size() != 0) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check({name, "_busy_low"}, 47'(busy), 47'(0));
      check({name, "_replies_done"}, 47'(exp_tx.size()), 47'(0));
   endtask

   task automatic pulse_reset(input int n);
      @(negedge clk);
      sys_rst_n = 1'b0;
      repeat (n) @(negedge clk);
      cmd_buf.delete();
      sys_rst_n = 1'b1;
   endtask

   // Per-cycle compare: reset values while held in reset, every csr_we strobe against the model.
   always @(negedge clk) begin
      if (!rst_at_edge) begin
         check("rst_uart_tx", 47'(uart_tx), 47'(1));
         check("rst_busy", 47'(busy), 47'(0));
         check("rst_csr_we", 47'(bus.csr_we), 47'(0));
         check("rst_csr_a", 47'(bus.csr_a), 47'(0));
         check("rst_csr_do", 47'(bus.csr_do), 47'(0));
      end else if (bus.csr_we !== 1'b0) begin
         wr_log.push_back({bus.csr_a, bus.csr_do});
         check("csr_we_expected", 47'(exp_wr.size() != 0), 47'(1));
         if (exp_wr.size() != 0) check("csr_write", {bus.csr_a, bus.csr_do}, exp_wr.pop_front());
      end
   end

   initial begin
      logic [7:0] b;
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (uart_tx === 1'b0) begin
            repeat (7) @(negedge clk);
            if (uart_tx === 1'b0) begin
               for (int i = 0; i < 8; i++) begin
                  repeat (16) @(negedge clk);
                  b[i] = uart_tx;
               end
               repeat (16) @(negedge clk);
               check("tx_stop_bit", 47'(uart_tx), 47'(1));
               tx_log.push_back(b);
               check("tx_byte_expected", 47'(exp_tx.size() != 0), 47'(1));
               if (exp_tx.size() != 0) begin
                  e = exp_tx.pop_front();
                  check("tx_byte", 47'(b), 47'(e));
               end
            end
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
      $fatal(1, "watchdog");
   end

   logic [7:0] cmd_wr1 [7] = '{8'h01, 8'h04, 8'h08, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
   logic [7:0] cmd_rd1 [3] = '{8'h02, 8'h00, 8'h01};
   logic [7:0] cmd_rd2 [3] = '{8'h02, 8'h85, 8'h10};
   logic [7:0] cmd_wr2 [7] = '{8'h01, 8'hFF, 8'hFF, 8'h01, 8'h02, 8'h03, 8'h04};

   initial begin
      int k;
      int tx_n;
      int wr_n;
      idle(5);
      sys_rst_n = 1'b1;
      idle(10);

      foreach (cmd_wr1[i]) uart_send(cmd_wr1[i], 1'b1, 1'b1);
      wait_idle("write");
      check("write_count", 47'(wr_log.size()), 47'(1));
      check("write_literal", wr_log[$], {15'h0408, 32'hDEAD_BEEF});
      check("write_ack_literal", 47'(tx_log[$]), 47'(8'hAA));
      check("csr_a_holds", 47'(bus.csr_a), 47'(15'h0408));

      foreach (cmd_rd1[i]) uart_send(cmd_rd1[i], 1'b1, 1'b1);
      wait_idle("read");
      k = tx_log.size();
      check("read_len", 47'(k >= 5), 47'(1));
      if (k >= 5) begin
         check("read_b3", 47'(tx_log[k-4]), 47'(8'h12));
         check("read_b2", 47'(tx_log[k-3]), 47'(8'h34));
         check("read_b1", 47'(tx_log[k-2]), 47'(8'h56));
         check("read_b0", 47'(tx_log[k-1]), 47'(8'h78));
      end
      check("read_no_write", 47'(wr_log.size()), 47'(1));
      check("csr_do_holds", 47'(bus.csr_do), 47'(32'hDEAD_BEEF));

      uart_send(8'h7F, 1'b1, 1'b1);
      wait_idle("bad_cmd");
      check("nak_literal", 47'(tx_log[$]), 47'(8'hEE));
      foreach (cmd_rd2[i]) uart_send(cmd_rd2[i], 1'b1, 1'b1);
      wait_idle("read_after_nak");
      check("ah7_ignored", 47'(bus.csr_a), 47'(15'h0510));

      tx_n = tx_log.size();
      uart_send(8'h01, 1'b0, 1'b0);
      idle(48);
      check("framing_busy", 47'(busy), 47'(0));
      check("framing_no_reply", 47'(tx_log.size()), 47'(tx_n));
      foreach (cmd_wr2[i]) uart_send(cmd_wr2[i], 1'b1, 1'b1);
      wait_idle("write_after_framing");
      check("write_max_addr", wr_log[$], {15'h7FFF, 32'h0102_0304});

      tx_n = tx_log.size();
      @(negedge clk);
      uart_rx = 1'b0;
      idle(4);
      uart_rx = 1'b1;
      idle(64);
      check("glitch_busy", 47'(busy), 47'(0));
      check("glitch_no_reply", 47'(tx_log.size()), 47'(tx_n));

      wr_n = wr_log.size();
      for (int i = 0; i < 5; i++) uart_send(cmd_wr1[i], 1'b1, 1'b1);
      idle(4);
      check("midwr_busy", 47'(busy), 47'(1));
      pulse_reset(3);
      idle(200);
      check("midwr_no_strobe", 47'(wr_log.size()), 47'(wr_n));
      check("midwr_uart_tx", 47'(uart_tx), 47'(1));
      check("midwr_busy_after", 47'(busy), 47'(0));
      foreach (cmd_rd1[i]) uart_send(cmd_rd1[i], 1'b1, 1'b1);
      wait_idle("read_after_reset");

      tx_n = tx_log.size();
      uart_send(8'h02, 1'b1, 1'b1);
      uart_send(8'h00, 1'b1, 1'b1);
      idle(1900);
      check("partial_still_busy", 47'(busy), 47'(1));
      idle(200);
`ifdef UART_CSR_BRIDGE_TIMEOUT_EN
      check("timeout_busy", 47'(busy), 47'(0));
      cmd_buf.delete();
`else
      check("no_timeout_busy", 47'(busy), 47'(1));
      pulse_reset(3);
`endif
      idle(20);
      check("timeout_no_reply", 47'(tx_log.size()), 47'(tx_n));
      foreach (cmd_rd1[i]) uart_send(cmd_rd1[i], 1'b1, 1'b1);
      wait_idle("read_final");

      check("all_writes_seen", 47'(exp_wr.size()), 47'(0));
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
